lcd_sequencer: RTL and testbench
================================

# lcd_sequencer

Write-only HD44780-style character LCD controller for the memory-mapped output GPIO space of the single-cycle RISC-V FPGA build. It buffers command/data bytes from the LSU in a small FIFO and runs a power-up init sequence after reset. It then replays each buffered byte onto the LCD pin word with correct setup / enable-pulse / hold / execution-wait timing, so software never bit-bangs the enable line. The same 32-bit LCD pin word feeds the board LCD pins.

## Interface
- SETUP_CYC, 2: cycles RS/DATA are stable before EN rises (≥1)
- PULSE_CYC, 25: cycles EN is held high (≥1)
- HOLD_CYC, 2: cycles RS/DATA stay stable after EN falls (≥1)
- CMD_WAIT_CYC, 2000: execution wait after a normal command/data byte (≥1)
- CLEAR_WAIT_CYC, 82000: execution wait after clear (0x01) or home (0x02/0x03) commands (≥1)
- PWRUP_CYC, 750000: idle wait after reset before the init sequence (≥1)
- FIFO_DEPTH, 8: buffer entries, power of two ≥2
- i_clk  in  1  clock; one clock domain; all state changes on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_wr_valid  in  1  LSU offers one byte this cycle
- i_wr_rs  in  1  1 = character data, 0 = instruction
- i_wr_data  in  8  byte to send
- o_wr_ready  out  1  FIFO can accept; transfer occurs when i_wr_valid & o_wr_ready
- i_lcd_on  in  1  LCD power/backlight request
- o_busy  out  1  high while init pending, FIFO non-empty, or FSM not IDLE (readable status for software)
- o_fifo_count  out  log2(FIFO_DEPTH)+1  entries currently buffered
- o_io_lcd  out  32  pin word: [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA; all other bits 0

## Operation
- FIFO: entry = {rs, data}. Push on accepted write; pop only by FSM in IDLE. o_wr_ready = (count != FIFO_DEPTH), computed from the registered count. A push is refused when full, even if a pop happens in the same cycle. Simultaneous push+pop at non-full, non-empty: count unchanged, order preserved. Pointers wrap modulo FIFO_DEPTH.
- Init ROM, issued in order as rs=0 commands: 0x38, 0x0C, 0x01, 0x06. Init uses the same SETUP/PULSE/HOLD/WAIT path as FIFO entries. The FIFO accepts writes during init but is not drained until all four commands finish.
- FSM states:
  - PWRUP: counts PWRUP_CYC cycles, then goes to IDLE.
  - IDLE: if init is incomplete, load the next ROM byte, otherwise pop the FIFO head if non-empty. Latch rs/data, then go to SETUP. If nothing is available, stay.
  - SETUP: EN=0, RS/DATA driven, for SETUP_CYC cycles.
  - PULSE: EN=1 for PULSE_CYC cycles.
  - HOLD: EN=0, RS/DATA unchanged, for HOLD_CYC cycles.
  - WAIT: EN=0 for CLEAR_WAIT_CYC if rs=0 and data∈{0x01,0x02,0x03}, else CMD_WAIT_CYC; then IDLE.
- RW is always 0. RS/DATA keep the last sent value while IDLE.
- One shared down-counter, sized for the largest parameter, is loaded on each state entry.
- o_io_lcd[31] = registered i_lcd_on. It is independent of the FSM and does not block sequencing.
- Reset has priority over every other action, including mid-pulse. On reset: the FIFO is flushed, init restarts from PWRUP, and EN drops at that edge.

## Timing
- Reset values: o_io_lcd = 0, o_fifo_count = 0, o_wr_ready = 1, o_busy = 1, state PWRUP.
- Per byte from the IDLE pop/load cycle: 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC + WAIT cycles before IDLE is entered again.
- RS/DATA change on the edge leaving IDLE. EN rises at the edge entering PULSE and falls at the edge entering HOLD.
- Back-to-back FIFO entries have no extra gap beyond the single IDLE cycle.
- o_fifo_count and o_wr_ready update on the edge after a push/pop.
- o_busy falls at the edge entering IDLE with init done and the FIFO empty.

## Test plan
Bench parameters: SETUP=2, PULSE=3, HOLD=2, CMD_WAIT=10, CLEAR_WAIT=40, PWRUP=20, DEPTH=4.
- Reset release, no writes:
  - o_io_lcd=0 for 20 cycles.
  - Then four EN pulses with DATA 0x38, 0x0C, 0x01, 0x06, RS=0, each exactly 3 cycles wide.
  - Gap after 0x01 reflects the 40-cycle wait; others reflect the 10-cycle wait.
  - o_busy falls after 0x06 completes.
- After init, write rs=1, data 0x41:
  - Pin word shows RS=1, DATA=0x41 one cycle after pop.
  - EN high 3 cycles starting 2 cycles later.
  - Byte-to-IDLE total is 1+2+3+2+10 = 18 cycles.
- Burst of 6 writes with i_wr_valid held:
  - Accepted in order up to the limit, with o_fifo_count reaching 4 and o_wr_ready dropping to 0.
  - The extra write waits; no byte is lost or reordered on the pins.
- Push while full on the same cycle as a pop: push refused that cycle, accepted the next cycle, count returns to 4.
- Command 0x02 then 0x80: wait after 0x02 is 40 cycles, after 0x80 is 10 cycles.
- Assert i_rst during PULSE:
  - EN=0 and o_io_lcd=0 at the next edge; FIFO count 0.
  - Init sequence repeats from PWRUP.
  - Toggling i_lcd_on mid-byte changes only bit 31, one cycle later.

Source files
------------

// File: rtl/lcd_sequencer.sv
// lcd_sequencer
// Write-only HD44780-style character LCD controller for the memory-mapped
// GPIO output space. Bytes written by the LSU are buffered in a small FIFO.
// After reset the block waits out the panel power-up time and issues a fixed
// init sequence. It then replays each buffered byte onto the LCD pin word with
// setup, enable pulse, hold and execution-wait timing handled in hardware.
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_rst         synchronous active-high reset
//   i_wr_valid    LSU offers a byte this cycle
//   i_wr_rs       1 = character data, 0 = instruction
//   i_wr_data     byte to send
//   o_wr_ready    FIFO can accept (transfer on i_wr_valid & o_wr_ready)
//   i_lcd_on      LCD power/backlight request
//   o_busy        init pending, FIFO non-empty, or sequencer not idle
//   o_fifo_count  entries currently buffered
//   o_io_lcd      pin word: [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA
module lcd_sequencer #(
  parameter int SETUP_CYC      = 2,
  parameter int PULSE_CYC      = 25,
  parameter int HOLD_CYC       = 2,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int PWRUP_CYC      = 750000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr_valid,
  input  logic                          i_wr_rs,
  input  logic [7:0]                    i_wr_data,
  output logic                          o_wr_ready,
  input  logic                          i_lcd_on,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [31:0]                   o_io_lcd
);

  localparam int AW = $clog2(FIFO_DEPTH);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The single shared counter must hold the largest load value of any state.
  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, CMD_WAIT_CYC)),
                                max2(CLEAR_WAIT_CYC, PWRUP_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

  // Each state lasts N cycles: the counter is loaded with N-1 on entry and
  // the state is left on the cycle it reads zero.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_WAIT_CYC - 1);
  localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      init_idx;
  logic            init_done;
  logic [7:0]      rom_byte;
  logic            rs_q;
  logic [7:0]      data_q;
  logic            on_q;
  logic            load;
  logic            pop;
  logic            push;
  logic            load_rs;
  logic [7:0]      load_data;
  logic            is_clear;

  logic [8:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  assign init_done = (init_idx == 3'd4);

  always_comb begin
    rom_byte = 8'h38;
    case (init_idx[1:0])
      2'd0: rom_byte = 8'h38;
      2'd1: rom_byte = 8'h0C;
      2'd2: rom_byte = 8'h01;
      2'd3: rom_byte = 8'h06;
      default: rom_byte = 8'h38;
    endcase
  end

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign is_clear = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  // Readiness comes from the registered count only, so a full FIFO refuses a
  // push even when the sequencer pops in the same cycle.
  assign o_wr_ready = (count != FULL_CNT);
  assign push       = i_wr_valid && o_wr_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - CW'(1) : cnt;
    load      = 1'b0;
    pop       = 1'b0;
    load_rs   = 1'b0;
    load_data = rom_byte;
    unique case (state)
      ST_PWRUP: begin
        if (cnt == '0) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // Init bytes take precedence; the FIFO is only drained once all four
        // init commands have completed.
        if (!init_done) begin
          load      = 1'b1;
          load_rs   = 1'b0;
          load_data = rom_byte;
          state_nxt = ST_SETUP;
          cnt_nxt   = SETUP_LD;
        end else if (count != '0) begin
          load                 = 1'b1;
          pop                  = 1'b1;
          {load_rs, load_data} = fifo_mem[rd_ptr];
          state_nxt            = ST_SETUP;
          cnt_nxt              = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = is_clear ? CLEAR_LD : CMD_LD;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_PWRUP;
        cnt_nxt   = PWRUP_LD;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_PWRUP;
      cnt      <= PWRUP_LD;
      init_idx <= 3'd0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      on_q     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      on_q  <= i_lcd_on;
      if (load) begin
        rs_q   <= load_rs;
        data_q <= load_data;
      end
      if (load && !init_done) init_idx <= init_idx + 3'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= {i_wr_rs, i_wr_data};
  end

  assign o_busy       = !init_done || (count != '0) || (state != ST_IDLE);
  assign o_fifo_count = count;
  assign o_io_lcd     = {on_q, 20'd0, (state == ST_PULSE), rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer
// Self-checking bench for lcd_sequencer using short timing parameters.
// Expected pulses are queued when stimulus is applied; a monitor records each
// observed EN pulse (RS, DATA, rise cycle, width) for the tests to compare.
module tb_lcd_sequencer;

  localparam int SETUP = 2;
  localparam int PULSE = 3;
  localparam int HOLD  = 2;
  localparam int CMDW  = 10;
  localparam int CLRW  = 40;
  localparam int PWRUP = 20;
  localparam int DEPTH = 4;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         width;
  } pulse_t;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_rs;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        lcd_on;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [31:0] io_lcd;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pulse_t exp_q[$];
  pulse_t obs_q[$];
  pulse_t cur;
  logic   en_prev = 1'b0;

  lcd_sequencer #(
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD), .CMD_WAIT_CYC(CMDW),
    .CLEAR_WAIT_CYC(CLRW), .PWRUP_CYC(PWRUP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_rs(wr_rs),
    .i_wr_data(wr_data), .o_wr_ready(wr_ready), .i_lcd_on(lcd_on),
    .o_busy(busy), .o_fifo_count(fifo_count), .o_io_lcd(io_lcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every EN pulse seen on the pins, sampled on the falling edge.
  always @(negedge clk) begin
    if (io_lcd[10] && !en_prev) begin
      cur.rs    = io_lcd[9];
      cur.data  = io_lcd[7:0];
      cur.rise  = cyc;
      cur.width = 0;
    end
    if (io_lcd[10]) cur.width = cur.width + 1;
    if (!io_lcd[10] && en_prev) obs_q.push_back(cur);
    en_prev = io_lcd[10];
  end

  // Offer one byte and keep offering until accepted; valid is left high so
  // consecutive calls form a held-valid burst.
  task automatic write_byte(input logic rs, input logic [7:0] data, input int rise_off,
                            output bit ok, output int acc);
    bit     rdy;
    pulse_t e;
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = data;
    ok       = 1'b0;
    acc      = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      rdy = wr_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
    if (ok) begin
      e.rs    = rs;
      e.data  = data;
      e.rise  = (rise_off >= 0) ? acc + rise_off : -1;
      e.width = PULSE;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    for (int i = 0; i < 600 && obs_q.size() < n; i++) @(negedge clk);
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic push_init(input int c0);
    pulse_t e;
    logic [7:0] rom [4];
    int         rises [4];
    rom   = '{8'h38, 8'h0C, 8'h01, 8'h06};
    rises = '{23, 41, 59, 107};
    for (int i = 0; i < 4; i++) begin
      e.rs = 1'b0; e.data = rom[i]; e.rise = c0 + rises[i]; e.width = PULSE;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    int c0, at;
    bit ok, allz;
    pulse_t e, o;
    rst = 1'b1; wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00; lcd_on = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    c0  = cyc;
    checks++; if (io_lcd !== 32'h0) begin failures++; $display("[TB] FAIL reset_io: got %h expected 00000000", io_lcd); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", wr_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    allz = 1'b1;
    for (int i = 1; i < PWRUP; i++) begin
      @(negedge clk);
      if (io_lcd !== 32'h0) allz = 1'b0;
    end
    checks++; if (!allz) begin failures++; $display("[TB] FAIL pwrup_quiet: got activity expected io=0 for %0d cycles", PWRUP); end
    push_init(c0);
    wait_obs(4, ok);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL init_timeout: got %0d pulses expected 4", obs_q.size());
      exp_q.delete(); obs_q.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if ({o.rs, o.data} !== {e.rs, e.data}) begin failures++; $display("[TB] FAIL init_byte%0d: got %b/%h expected %b/%h", i, o.rs, o.data, e.rs, e.data); end
        checks++; if (o.width != e.width) begin failures++; $display("[TB] FAIL init_width%0d: got %0d expected %0d", i, o.width, e.width); end
        checks++; if (o.rise != e.rise) begin failures++; $display("[TB] FAIL init_rise%0d: got %0d expected %0d", i, o.rise, e.rise); end
      end
    end
    wait_idle(ok, at);
    checks++; if (at != c0 + 122) begin failures++; $display("[TB] FAIL init_busy_fall: got %0d expected %0d", at, c0 + 122); end
  endtask

  task automatic test_single_write();
    int acc, at;
    bit ok;
    pulse_t e, o;
    write_byte(1'b1, 8'h41, 3, ok, acc);
    wr_valid = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL single_accept: got refused expected accepted"); end
    @(negedge clk);
    checks++; if (io_lcd[10:0] !== {1'b0, 1'b1, 1'b0, 8'h41}) begin failures++; $display("[TB] FAIL single_pins: got %h expected %h", io_lcd[10:0], {1'b0, 1'b1, 1'b0, 8'h41}); end
    wait_idle(ok, at);
    checks++; if (at != acc + 18) begin failures++; $display("[TB] FAIL single_total: got %0d expected %0d", at, acc + 18); end
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL single_timeout: got %0d pulses expected 1", obs_q.size());
      exp_q.delete(); obs_q.delete();
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if ({o.rs, o.data} !== {e.rs, e.data}) begin failures++; $display("[TB] FAIL single_byte: got %b/%h expected %b/%h", o.rs, o.data, e.rs, e.data); end
      checks++; if (o.width != e.width) begin failures++; $display("[TB] FAIL single_width: got %0d expected %0d", o.width, e.width); end
      checks++; if (o.rise != e.rise) begin failures++; $display("[TB] FAIL single_rise: got %0d expected %0d", o.rise, e.rise); end
    end
  endtask

  task automatic test_burst();
    int acc, first_acc, last_acc, at, max_cnt;
    bit ok, all_ok, saw_full;
    pulse_t e, o;
    all_ok = 1'b1; saw_full = 1'b0; max_cnt = 0; first_acc = 0; last_acc = 0;
    for (int k = 0; k < 6; k++) begin
      write_byte(1'b1, 8'h50 + 8'(k), (k < 5) ? 3 + 17 * k : 73, ok, acc);
      if (!ok) all_ok = 1'b0;
      if (k == 0) first_acc = acc;
      last_acc = acc;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (!wr_ready) saw_full = 1'b1;
    end
    wr_valid = 1'b0;
    checks++; if (!all_ok) begin failures++; $display("[TB] FAIL burst_accept: got refused expected all accepted"); end
    checks++; if (max_cnt != DEPTH) begin failures++; $display("[TB] FAIL burst_count: got %0d expected %0d", max_cnt, DEPTH); end
    checks++; if (!saw_full) begin failures++; $display("[TB] FAIL burst_ready: got ready stuck 1 expected 0 when full"); end
    checks++; if (last_acc - first_acc != 20) begin failures++; $display("[TB] FAIL burst_stall: got %0d expected 20", last_acc - first_acc); end
    wait_obs(6, ok);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL burst_timeout: got %0d pulses expected 6", obs_q.size());
      exp_q.delete(); obs_q.delete();
    end else begin
      for (int i = 0; i < 6; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if ({o.rs, o.data} !== {e.rs, e.data}) begin failures++; $display("[TB] FAIL burst_byte%0d: got %b/%h expected %b/%h", i, o.rs, o.data, e.rs, e.data); end
        checks++; if (o.width != e.width) begin failures++; $display("[TB] FAIL burst_width%0d: got %0d expected %0d", i, o.width, e.width); end
        checks++; if (o.rise != e.rise) begin failures++; $display("[TB] FAIL burst_rise%0d: got %0d expected %0d", i, o.rise, e.rise); end
      end
    end
    wait_idle(ok, at);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL burst_idle: got busy expected idle"); end
  endtask

  task automatic test_full_pop();
    int acc, at;
    bit ok, saw3;
    pulse_t e, o;
    for (int k = 0; k < 5; k++) write_byte(1'b1, 8'h60 + 8'(k), -1, ok, acc);
    wr_valid = 1'b1; wr_rs = 1'b0; wr_data = 8'hC5;
    saw3 = 1'b0;
    for (int i = 0; i < 60 && !saw3; i++) begin
      @(negedge clk);
      if (fifo_count == 3'd3) saw3 = 1'b1;
    end
    checks++; if (!saw3) begin failures++; $display("[TB] FAIL full_pop_refuse: got count %0d expected 3 after pop", fifo_count); end
    @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("[TB] FAIL full_pop_refill: got %0d expected 4", fifo_count); end
    e.rs = 1'b0; e.data = 8'hC5; e.rise = -1; e.width = PULSE;
    exp_q.push_back(e);
    wait_obs(6, ok);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL full_pop_timeout: got %0d pulses expected 6", obs_q.size());
      exp_q.delete(); obs_q.delete();
    end else begin
      for (int i = 0; i < 6; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if ({o.rs, o.data} !== {e.rs, e.data}) begin failures++; $display("[TB] FAIL full_pop_byte%0d: got %b/%h expected %b/%h", i, o.rs, o.data, e.rs, e.data); end
      end
    end
    wait_idle(ok, at);
    checks++; if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL full_pop_extra: got %0d extra pulses expected 0", obs_q.size()); end
  endtask

  task automatic test_clear_wait();
    int acc, acc2, at;
    bit ok;
    pulse_t e, o;
    write_byte(1'b0, 8'h02, 3, ok, acc);
    write_byte(1'b0, 8'h80, 50, ok, acc2);
    wr_valid = 1'b0;
    wait_obs(2, ok);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL clear_timeout: got %0d pulses expected 2", obs_q.size());
      exp_q.delete(); obs_q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if ({o.rs, o.data} !== {e.rs, e.data}) begin failures++; $display("[TB] FAIL clear_byte%0d: got %b/%h expected %b/%h", i, o.rs, o.data, e.rs, e.data); end
        checks++; if (o.rise != e.rise) begin failures++; $display("[TB] FAIL clear_rise%0d: got %0d expected %0d", i, o.rise, e.rise); end
      end
    end
    wait_idle(ok, at);
    checks++; if (at != acc + 66) begin failures++; $display("[TB] FAIL clear_cmd_wait: got %0d expected %0d", at, acc + 66); end
  endtask

  task automatic test_reset_mid_pulse();
    int acc, c0, at;
    bit ok, found;
    logic [31:0] snap;
    pulse_t e, o;
    lcd_on = 1'b1;
    write_byte(1'b1, 8'h33, -1, ok, acc);
    write_byte(1'b1, 8'h34, -1, ok, acc);
    write_byte(1'b1, 8'h35, -1, ok, acc);
    wr_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (io_lcd[10]) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL rst_find_pulse: got EN low expected a pulse"); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (io_lcd !== 32'h0) begin failures++; $display("[TB] FAIL rst_pulse_io: got %h expected 00000000", io_lcd); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL rst_pulse_count: got %0d expected 0", fifo_count); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_pulse_busy: got %b expected 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    c0  = cyc;
    exp_q.delete();
    obs_q.delete();
    push_init(c0);
    wait_obs(1, ok);
    snap = io_lcd;
    checks++; if (snap[31] !== 1'b1) begin failures++; $display("[TB] FAIL lcd_on_high: got %b expected 1", snap[31]); end
    lcd_on = 1'b0;
    @(negedge clk);
    checks++; if (io_lcd !== {1'b0, snap[30:0]}) begin failures++; $display("[TB] FAIL lcd_on_toggle: got %h expected %h", io_lcd, {1'b0, snap[30:0]}); end
    wait_obs(4, ok);
    checks++;
    if (!ok) begin
      failures++; $display("[TB] FAIL rst_init_timeout: got %0d pulses expected 4", obs_q.size());
      exp_q.delete(); obs_q.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if ({o.rs, o.data} !== {e.rs, e.data}) begin failures++; $display("[TB] FAIL rst_init_byte%0d: got %b/%h expected %b/%h", i, o.rs, o.data, e.rs, e.data); end
        checks++; if (o.rise != e.rise) begin failures++; $display("[TB] FAIL rst_init_rise%0d: got %0d expected %0d", i, o.rise, e.rise); end
      end
    end
    wait_idle(ok, at);
    checks++; if (at != c0 + 122) begin failures++; $display("[TB] FAIL rst_init_busy_fall: got %0d expected %0d", at, c0 + 122); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_full_pop();
    test_clear_wait();
    test_reset_mid_pulse();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL leftover: got exp=%0d obs=%0d expected 0/0", exp_q.size(), obs_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
